ant_buf_wr: RTL
===============

# ant_buf_wr

Write-side controller for the X-engine's ping-pong antenna sample buffer. It accepts a stream of per-antenna sample words, packs each group of N_ANTS words into one of two memory banks, and tracks which banks hold complete data. It starts and gates the downstream baseline-order generator through `bl_sync` and `bl_en`, and takes bank-release pulses back from that side. It does not apply backpressure: when both banks are occupied it drops input and flags the loss.

## Interface
- `N_ANTS`, 16: antennas per bank; must be a power of two, at least 2.
- `DATA_W`, 8: sample word width in bits.
- `ANT_BITS`, log2(N_ANTS): localparam, derived.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  input word valid.
- `in_sof`  in  1  qualified by `in_valid`; marks antenna 0 of a group.
- `in_data`  in  DATA_W  sample word.
- `rd_release`  in  1  one-cycle pulse; the reader has finished the bank selected by `rd_bank`.
- `wr_en`  out  1  memory write strobe.
- `wr_addr`  out  ANT_BITS+1  memory write address; MSB is the bank, LSBs are the antenna index.
- `wr_data`  out  DATA_W  memory write data.
- `rd_bank`  out  1  bank currently owned by the reader.
- `bl_sync`  out  1  one-cycle start pulse to the baseline-order generator.
- `bl_en`  out  1  reader enable; high while `bank_full[rd_bank]` is set.
- `bank_full`  out  2  per-bank complete flag.
- `overflow`  out  1  one-cycle pulse per dropped input word.
- `misalign`  out  1  one-cycle pulse when `in_sof` arrives in mid-group.

## Operation
- State machine states:
  - IDLE: discard words until `in_valid & in_sof`. That word is written at antenna 0 and the state moves to FILL.
  - FILL: each valid word is written at `{wr_bank, ant_cnt}` and `ant_cnt` increments.
    - A valid word with `ant_cnt == N_ANTS-1` completes the bank: set `bank_full[wr_bank]`, clear `ant_cnt`, toggle `wr_bank`.
    - If `bank_full` of the new `wr_bank` is already set, go to WAIT. Otherwise stay in FILL.
  - WAIT: every valid word is dropped, with one `overflow` pulse per word. When `bank_full[wr_bank]` clears, go to IDLE, which resynchronises on the next `in_sof`.
- `in_sof` in FILL with `ant_cnt != 0`:
  - Pulse `misalign`.
  - Write the word at antenna 0 of the current bank and set `ant_cnt` to 1.
  - The partial group is abandoned; `bank_full` is not set.
- `in_sof` with `ant_cnt == 0` is legal and silent. Groups without `in_sof` are accepted once the FSM is in FILL.
- Reader side:
  - `rd_release` clears `bank_full[rd_bank]` and toggles `rd_bank`.
  - `rd_release` while `bank_full[rd_bank]` is clear is ignored; `rd_bank` does not toggle.
- `bl_sync` fires exactly once after reset, on the first bank completion. Later completions do not pulse it.
- Simultaneous events in the same cycle:
  - Completion and release of the other bank: the release is applied first, so the FSM stays in FILL with no drop.
  - Completion and release of the same bank cannot occur, because the reader never owns the bank being written.
- Reset, including mid-operation:
  - Returns to IDLE and clears all flags and counters.
  - `wr_bank = 0`, `rd_bank = 0`.
  - Any partially written bank is discarded.
- `ant_cnt` is ANT_BITS wide and wraps naturally at the last antenna.

## Timing
- Reset values: every output is 0, including `wr_addr`, `wr_data` and `bank_full`.
- Write path: registered. The input word at cycle t appears on `wr_en`, `wr_addr` and `wr_data` at cycle t+1.
- `bank_full`: the bit sets at t+1 for a completing word at t, in the same cycle the last word is written.
- `bl_sync` and `bl_en`: `bl_sync` pulses at t+2, so the last write has already landed in memory. `bl_en` rises at t+2 and stays high while `bank_full[rd_bank]`.
- Release path: `rd_release` at cycle r gives `rd_bank` toggled and `bank_full` cleared at r+1, and `bl_en` updated at r+1.
- `overflow` and `misalign` pulse at t+1 relative to the offending input word.
- Throughput: one word per cycle sustained. Back-to-back groups need no idle cycles.

## Structure
- Shared package `xeng_pkg` holds:
  - the `log2` macro/function already used across `xeng_lib`;
  - FSM state encoding as localparams: IDLE = 0, FILL = 1, WAIT = 2;
  - the bank-address packing rule `{bank, ant}`, shared with the reader's address formation.
- One natural sub-module, `bank_tracker`, owns `bank_full`, `rd_bank`, release handling and same-cycle priority.
- The FSM and write-path registers stay in the top level.
- The sample memory itself is external to this block.

## Test plan
- **Clean fill**, N_ANTS=16, DATA_W=8: `in_sof` followed by 16 words 0x10..0x1F.
  - Addresses 0x00..0x0F written with matching data.
  - `bank_full` = 2'b01 after the last write.
  - `bl_sync` pulses once, 2 cycles after the last input; `bl_en` = 1.
- **Ping-pong**: 3 groups back-to-back, with `rd_release` after group 1.
  - Addresses 0x00–0x0F, then 0x10–0x1F, then 0x00–0x0F again.
  - No `overflow`; `rd_bank` toggles to 1.
- **Overflow**: 3 groups back-to-back, no `rd_release`.
  - Third group produces 16 `overflow` pulses and 0 writes; FSM in WAIT.
  - After `rd_release`, the next `in_sof` group is written to bank 0.
- **Misalign**: `in_sof` at word 5 of a group.
  - One `misalign` pulse; that word is written at antenna 0.
  - The bank completes 15 words later.
- **Simultaneous events**: `rd_release` in the same cycle as bank 1's last word while bank 0 is full.
  - No `overflow`; `bank_full` goes to 2'b10; writing continues in bank 0.
- **Reset mid-fill**: assert `rst_n` low after 7 words.
  - All outputs 0; `bl_sync` fires again on the next completed group.

Source files
------------

// File: rtl/xeng_pkg.sv
// rtl/xeng_pkg.sv - shared X-engine types and helpers
// Write-FSM encoding, log2 and the {bank, ant} buffer address rule.
package xeng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_WAIT = 2'd2
  } wr_state_e;

  function automatic int log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // The reader forms its addresses with this same rule.
  function automatic logic [31:0] pack_addr(input logic bank, input logic [31:0] ant,
                                            input int ant_bits);
    return (32'(bank) << ant_bits) | ant;
  endfunction

endpackage

// File: rtl/bank_tracker.sv
// rtl/bank_tracker.sv - ping-pong bank ownership and completion flags
// Release is applied before a same-cycle completion so the writer sees the freed bank.
module bank_tracker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_valid_i,
  input  logic       set_bank_i,
  input  logic       release_i,
  output logic [1:0] bank_full_o,
  output logic [1:0] bank_full_rel_o,
  output logic       rd_bank_o,
  output logic       bl_en_o
);

  logic [1:0] full_q, full_d, full_rel;
  logic       rd_bank_q, rd_bank_d;
  logic       bl_en_q, bl_en_d;
  logic       rel_ok;

  always_comb begin
    rel_ok    = release_i & full_q[rd_bank_q];
    full_rel  = full_q;
    rd_bank_d = rd_bank_q;
    if (rel_ok) begin
      full_rel[rd_bank_q] = 1'b0;
      rd_bank_d           = ~rd_bank_q;
    end
    full_d = full_rel;
    if (set_valid_i) full_d[set_bank_i] = 1'b1;
    // A fresh completion reaches bl_en one cycle after bank_full; a release is immediate.
    bl_en_d = full_rel[rd_bank_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= 2'b00;
      rd_bank_q <= 1'b0;
      bl_en_q   <= 1'b0;
    end else begin
      full_q    <= full_d;
      rd_bank_q <= rd_bank_d;
      bl_en_q   <= bl_en_d;
    end
  end

  assign bank_full_o     = full_q;
  assign bank_full_rel_o = full_rel;
  assign rd_bank_o       = rd_bank_q;
  assign bl_en_o         = bl_en_q;

endmodule

// File: rtl/ant_buf_wr.sv
// rtl/ant_buf_wr.sv - write-side controller for the ping-pong antenna buffer
// Packs N_ANTS-word groups into alternate banks and drops input while both are full.
module ant_buf_wr
  import xeng_pkg::*;
#(
  parameter int  N_ANTS   = 16,
  parameter int  DATA_W   = 8,
  localparam int ANT_BITS = log2(N_ANTS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic                in_sof,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                rd_release,
  output logic                wr_en,
  output logic [ANT_BITS:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic                rd_bank,
  output logic                bl_sync,
  output logic                bl_en,
  output logic [1:0]          bank_full,
  output logic                overflow,
  output logic                misalign
);

  localparam int                  ADDR_W   = ANT_BITS + 1;
  localparam logic [ANT_BITS-1:0] LAST_ANT = ANT_BITS'(N_ANTS - 1);

  wr_state_e           state_q, state_d;
  logic [ANT_BITS-1:0] ant_cnt_q, ant_cnt_d;
  logic                wr_bank_q, wr_bank_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                overflow_q, overflow_d;
  logic                misalign_q, misalign_d;
  logic                sync_pend_q, synced_q, bl_sync_q;
  logic                complete;
  logic [1:0]          bank_full_rel;

  function automatic logic [ADDR_W-1:0] addr_of(input logic bank, input logic [ANT_BITS-1:0] ant);
    return ADDR_W'(pack_addr(bank, 32'(ant), ANT_BITS));
  endfunction

  always_comb begin
    state_d    = state_q;
    ant_cnt_d  = ant_cnt_q;
    wr_bank_d  = wr_bank_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    overflow_d = 1'b0;
    misalign_d = 1'b0;
    complete   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_sof) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_of(wr_bank_q, '0);
          wr_data_d = in_data;
          ant_cnt_d = ANT_BITS'(1);
          state_d   = ST_FILL;
        end
      end
      ST_FILL: begin
        if (in_valid) begin
          wr_en_d   = 1'b1;
          wr_data_d = in_data;
          if (in_sof && ant_cnt_q != '0) begin
            // Abandon the partial group and restart this bank at antenna 0.
            misalign_d = 1'b1;
            wr_addr_d  = addr_of(wr_bank_q, '0);
            ant_cnt_d  = ANT_BITS'(1);
          end else begin
            wr_addr_d = addr_of(wr_bank_q, ant_cnt_q);
            ant_cnt_d = ant_cnt_q + 1'b1;
            if (ant_cnt_q == LAST_ANT) begin
              complete  = 1'b1;
              wr_bank_d = ~wr_bank_q;
              if (bank_full_rel[~wr_bank_q]) state_d = ST_WAIT;
            end
          end
        end
      end
      ST_WAIT: begin
        overflow_d = in_valid;
        if (!bank_full_rel[wr_bank_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ant_cnt_q   <= '0;
      wr_bank_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      overflow_q  <= 1'b0;
      misalign_q  <= 1'b0;
      sync_pend_q <= 1'b0;
      synced_q    <= 1'b0;
      bl_sync_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ant_cnt_q   <= ant_cnt_d;
      wr_bank_q   <= wr_bank_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      overflow_q  <= overflow_d;
      misalign_q  <= misalign_d;
      sync_pend_q <= complete & ~synced_q;
      synced_q    <= synced_q | complete;
      bl_sync_q   <= sync_pend_q;
    end
  end

  bank_tracker u_bank_tracker (
    .clk             (clk),
    .rst_n           (rst_n),
    .set_valid_i     (complete),
    .set_bank_i      (wr_bank_q),
    .release_i       (rd_release),
    .bank_full_o     (bank_full),
    .bank_full_rel_o (bank_full_rel),
    .rd_bank_o       (rd_bank),
    .bl_en_o         (bl_en)
  );

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign overflow = overflow_q;
  assign misalign = misalign_q;
  assign bl_sync  = bl_sync_q;

endmodule
